// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns one memory-stage load/store into one or
// two word-aligned request/grant bus transactions, builds byte strobes and lane
// shifts, assembles and extends load data, and stalls the pipeline until done.
module dmem_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              ren,
    input  logic [2:0]        rwidth,
    input  logic              rsign,
    input  logic              wen,
    input  logic [2:0]        wwidth,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_t;

    state_t state_q, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        width_q;
    logic              sign_q;
    logic              load_q;
    logic              split_q;
    logic              err_q;
    logic [XLEN-1:0]   r0_q;

    function automatic logic [3:0] width_mask(input logic [2:0] w);
        case (w)
            3'd1:    return 4'h1;
            3'd2:    return 4'h3;
            3'd4:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    // Shift the two-word window down to the access offset, keep width bytes, extend.
    function automatic logic [XLEN-1:0] assemble(input logic [2*XLEN-1:0] v,
                                                 input logic [1:0] off,
                                                 input logic [2:0] w,
                                                 input logic s);
        logic [XLEN-1:0] raw;
        raw = XLEN'(v >> {off, 3'b000});
        case (w)
            3'd1:    return {{(XLEN-8){s & raw[7]}}, raw[7:0]};
            3'd2:    return {{(XLEN-16){s & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Request decode at the IDLE boundary.
    logic [2:0]        in_w;
    logic              in_op;
    logic              in_err;
    logic              in_split;
    logic              req_fire;
    logic [3:0]        in_mask;
    logic [ADDR_W-1:0] h0_addr;
    logic [3:0]        h0_strb;
    logic [XLEN-1:0]   h0_wdata;

    assign in_w     = ren ? rwidth : wwidth;
    assign in_op    = ren | wen;
    assign in_err   = (ren & wen) | ~(in_w == 3'd1 || in_w == 3'd2 || in_w == 3'd4);
    assign in_split = ({2'b00, addr[1:0]} + {1'b0, in_w}) > 4'd4;
    assign in_mask  = width_mask(in_w);
    assign h0_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign h0_strb  = in_mask << addr[1:0];
    assign h0_wdata = wdata << {addr[1:0], 3'b000};

    assign req_ready = (state_q == S_IDLE);
    assign req_fire  = req_valid & req_ready & in_op;

    // Second-half beat, derived from the latched request.
    logic [3:0]        mask_q;
    logic [2:0]        rem_q;
    logic [ADDR_W-1:0] h1_addr;
    logic [3:0]        h1_strb;
    logic [XLEN-1:0]   h1_wdata;

    assign mask_q   = width_mask(width_q);
    assign rem_q    = 3'd4 - {1'b0, addr_q[1:0]};
    assign h1_addr  = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
    assign h1_strb  = mask_q >> rem_q;
    assign h1_wdata = wdata_q >> {rem_q, 3'b000};

    assign stall      = req_valid & ((req_ready & in_op) | ~req_ready);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) & err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Next-state logic; rvalid during a REQ state is deliberately ignored.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (req_fire) state_n = in_err ? S_RESP : S_REQ0;
            S_REQ0:  if (bus_gnt) state_n = load_q ? S_WAIT0 : (split_q ? S_REQ1 : S_RESP);
            S_WAIT0: if (bus_rvalid) state_n = split_q ? S_REQ1 : S_RESP;
            S_REQ1:  if (bus_gnt) state_n = load_q ? S_WAIT1 : S_RESP;
            S_WAIT1: if (bus_rvalid) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Request latch, registered bus outputs and load-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            width_q   <= '0;
            sign_q    <= 1'b0;
            load_q    <= 1'b0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
            r0_q      <= '0;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        width_q <= in_w;
                        sign_q  <= rsign;
                        load_q  <= ren;
                        split_q <= in_split;
                        err_q   <= in_err;
                        if (!in_err) begin
                            bus_req   <= 1'b1;
                            bus_we    <= wen;
                            bus_addr  <= h0_addr;
                            bus_wstrb <= wen ? h0_strb : 4'h0;
                            bus_wdata <= wen ? h0_wdata : '0;
                        end
                    end
                end
                S_REQ0: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        // A split store chains straight into its second beat.
                        if (!load_q && split_q) begin
                            bus_req   <= 1'b1;
                            bus_addr  <= h1_addr;
                            bus_wstrb <= h1_strb;
                            bus_wdata <= h1_wdata;
                        end
                    end
                end
                S_WAIT0: begin
                    if (bus_rvalid) begin
                        r0_q <= bus_rdata;
                        if (split_q) begin
                            bus_req   <= 1'b1;
                            bus_addr  <= h1_addr;
                            bus_wstrb <= 4'h0;
                        end else begin
                            rdata <= assemble({{XLEN{1'b0}}, bus_rdata}, addr_q[1:0], width_q, sign_q);
                        end
                    end
                end
                S_REQ1: begin
                    if (bus_gnt) bus_req <= 1'b0;
                end
                S_WAIT1: begin
                    if (bus_rvalid) rdata <= assemble({bus_rdata, r0_q}, addr_q[1:0], width_q, sign_q);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: acts as memory stage and bus slave, with
// expected bus beats and responses queued when a request is driven.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        ren = 1'b0;
    logic [2:0]  rwidth = '0;
    logic        rsign = 1'b0;
    logic        wen = 1'b0;
    logic [2:0]  wwidth = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        err;
        logic        is_load;
        logic [31:0] rdata;
    } resp_t;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    logic [31:0] rd_q[$];

    dmem_access_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .ren(ren), .rwidth(rwidth), .rsign(rsign),
        .wen(wen), .wwidth(wwidth),
        .addr(addr), .wdata(wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte-by-byte reference for load assembly.
    function automatic logic [31:0] model_load(input logic [31:0] a, input int unsigned w,
                                               input logic s, input logic [31:0] r0,
                                               input logic [31:0] r1);
        logic [31:0] res;
        int unsigned pos;
        res = '0;
        for (int unsigned i = 0; i < w; i++) begin
            pos = a[1:0] + i;
            res[8*i +: 8] = (pos < 4) ? r0[8*pos +: 8] : r1[8*(pos-4) +: 8];
        end
        if (s && res[8*w-1])
            for (int unsigned i = w; i < 4; i++) res[8*i +: 8] = 8'hFF;
        return res;
    endfunction

    // Drive one request, serve the bus, and check beats, response and latency.
    task automatic do_txn(input logic r_en, input logic [2:0] rw, input logic rs,
                          input logic w_en, input logic [2:0] ww,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] r0w, input logic [31:0] r1w,
                          input int gnt_dly, input int rv_dly, input int exp_lat,
                          input logic rv_glitch,
                          output logic [31:0] got_rdata, output int nbeats);
        int unsigned w, off, pos;
        logic  err, split, done, waiting, stall_bad, hold_bad;
        logic [3:0]  s0, s1;
        logic [31:0] base, h_addr, h_wdata;
        logic [3:0]  h_strb;
        int lat, wcnt, rv_cnt;
        beat_t e;
        resp_t rexp;

        w   = r_en ? rw : ww;
        err = (r_en && w_en) || !(w == 1 || w == 2 || w == 4);
        if (err) begin
            resp_q.push_back('{1'b1, 1'b0, 32'h0});
        end else begin
            off   = a[1:0];
            base  = {a[31:2], 2'b00};
            split = (off + w) > 4;
            s0 = '0;
            s1 = '0;
            if (w_en)
                for (int unsigned i = 0; i < w; i++) begin
                    pos = off + i;
                    if (pos < 4) s0[pos] = 1'b1;
                    else         s1[pos-4] = 1'b1;
                end
            beat_q.push_back('{base, w_en, s0, wd << (8*off)});
            if (r_en) rd_q.push_back(r0w);
            if (split) begin
                beat_q.push_back('{base + 32'd4, w_en, s1, wd >> (8*(4-off))});
                if (r_en) rd_q.push_back(r1w);
            end
            resp_q.push_back('{1'b0, r_en, model_load(a, w, rs, r0w, r1w)});
        end

        @(negedge clk);
        req_valid = 1'b1; ren = r_en; rwidth = rw; rsign = rs;
        wen = w_en; wwidth = ww; addr = a; wdata = wd;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL accept: req_ready=%b stall=%b, want 1 1", req_ready, stall);
        end
        @(posedge clk);

        lat = 0; wcnt = 0; rv_cnt = 0; nbeats = 0; got_rdata = '0;
        done = 1'b0; waiting = 1'b0; stall_bad = 1'b0; hold_bad = 1'b0;
        h_addr = '0; h_strb = '0; h_wdata = '0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0BAD0BAD;
                end
            end
            if (stall !== 1'b1) stall_bad = 1'b1;
            if (resp_valid === 1'b1) begin
                done = 1'b1;
                got_rdata = rdata;
                n_cmp++;
                if (resp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL resp_unexpected: resp_valid=1 with no response queued");
                end else begin
                    rexp = resp_q.pop_front();
                    if (resp_err !== rexp.err || (rexp.is_load && rdata !== rexp.rdata)) begin
                        n_bad++;
                        $display("FAIL resp: err=%b rdata=%h, want err=%b rdata=%h",
                                 resp_err, rdata, rexp.err, rexp.rdata);
                    end
                end
                if (exp_lat > 0) begin
                    n_cmp++;
                    if (lat != exp_lat) begin
                        n_bad++;
                        $display("FAIL latency: %0d cycles, want %0d", lat, exp_lat);
                    end
                end
                req_valid = 1'b0; ren = 1'b0; wen = 1'b0;
            end else if (bus_req === 1'b1) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    wcnt = 0;
                    h_addr = bus_addr; h_strb = bus_wstrb; h_wdata = bus_wdata;
                end else if (bus_addr !== h_addr || bus_wstrb !== h_strb || bus_wdata !== h_wdata) begin
                    hold_bad = 1'b1;
                end
                if (wcnt == gnt_dly) begin
                    bus_gnt = 1'b1;
                    waiting = 1'b0;
                    nbeats++;
                    n_cmp++;
                    if (beat_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL beat_unexpected: addr=%h we=%b, want no bus request", bus_addr, bus_we);
                    end else begin
                        e = beat_q.pop_front();
                        if (bus_addr !== e.addr || bus_we !== e.we || bus_wstrb !== e.strb ||
                            (e.we && bus_wdata !== e.wdata)) begin
                            n_bad++;
                            $display("FAIL beat: addr=%h we=%b strb=%b wdata=%h, want addr=%h we=%b strb=%b wdata=%h",
                                     bus_addr, bus_we, bus_wstrb, bus_wdata, e.addr, e.we, e.strb, e.wdata);
                        end
                    end
                    if (bus_we !== 1'b1) begin
                        rv_cnt = rv_dly;
                        if (rv_glitch) begin
                            bus_rvalid = 1'b1;
                            bus_rdata  = 32'hDEADBEEF;
                        end
                    end
                end else begin
                    wcnt++;
                end
            end
        end
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no resp_valid after %0d cycles, want one", lat);
            req_valid = 1'b0; ren = 1'b0; wen = 1'b0;
        end
        n_cmp++;
        if (stall_bad) begin
            n_bad++;
            $display("FAIL stall_hold: stall dropped before resp, want 1 throughout");
        end
        if (gnt_dly > 0) begin
            n_cmp++;
            if (hold_bad) begin
                n_bad++;
                $display("FAIL bus_hold: bus outputs changed while ungranted, want stable");
            end
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL resp_pulse: resp_valid=%b req_ready=%b, want 0 1", resp_valid, req_ready);
        end
        n_cmp++;
        if (beat_q.size() != 0 || rd_q.size() != 0 || resp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: beats=%0d reads=%0d resps=%0d, want 0 0 0",
                     beat_q.size(), rd_q.size(), resp_q.size());
            beat_q.delete(); rd_q.delete(); resp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            rdata !== 32'h0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 ||
            bus_wstrb !== 4'h0 || bus_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b req=%b addr=%h strb=%b rdata=%h, want 1 0 0 0 0",
                     req_ready, bus_req, bus_addr, bus_wstrb, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_lw();
        logic [31:0] r;
        int nb;
        do_txn(1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 32'h100, 32'h0, 32'h80FF1234, 32'h0,
               0, 1, 3, 1'b1, r, nb);
        n_cmp++;
        if (r !== 32'h80FF1234) begin
            n_bad++;
            $display("FAIL lw_rdata: %h, want 80ff1234", r);
        end
    endtask

    task automatic test_lb_sign();
        logic [31:0] r;
        int nb;
        do_txn(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 32'h0,
               0, 1, 3, 1'b0, r, nb);
        n_cmp++;
        if (r !== 32'hFFFFFF80) begin
            n_bad++;
            $display("FAIL lb_signed: %h, want ffffff80", r);
        end
        do_txn(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 32'h0,
               0, 1, 3, 1'b0, r, nb);
        n_cmp++;
        if (r !== 32'h00000080) begin
            n_bad++;
            $display("FAIL lb_unsigned: %h, want 00000080", r);
        end
    endtask

    task automatic test_stores();
        logic [31:0] r;
        int nb;
        do_txn(1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 32'h80, 32'h11223344, 32'h0, 32'h0,
               0, 1, 2, 1'b0, r, nb);
        do_txn(1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 32'h81, 32'h000000A5, 32'h0, 32'h0,
               0, 1, 2, 1'b0, r, nb);
        do_txn(1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 32'h1FE, 32'hAABBCCDD, 32'h0, 32'h0,
               0, 1, 3, 1'b0, r, nb);
        n_cmp++;
        if (nb != 2) begin
            n_bad++;
            $display("FAIL split_sw_beats: %0d, want 2", nb);
        end
    endtask

    task automatic test_split_lh_wrap();
        logic [31:0] r;
        int nb;
        do_txn(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 32'hFFFFFFFF, 32'h0, 32'h12000000, 32'h000000F3,
               0, 1, 5, 1'b0, r, nb);
        n_cmp++;
        if (r !== 32'hFFFFF312 || nb != 2) begin
            n_bad++;
            $display("FAIL split_lh: rdata=%h beats=%0d, want fffff312 2", r, nb);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        int nb;
        do_txn(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 32'h42, 32'h1234ABCD, 32'h0, 32'h0,
               4, 1, 0, 1'b0, r, nb);
        do_txn(1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 32'h306, 32'h0, 32'h55667788, 32'h99AABBCC,
               3, 2, 0, 1'b0, r, nb);
    endtask

    task automatic test_error();
        logic [31:0] r;
        int nb;
        do_txn(1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 32'h0,
               0, 1, 1, 1'b0, r, nb);
        n_cmp++;
        if (nb != 0) begin
            n_bad++;
            $display("FAIL err_no_bus: %0d beats, want 0", nb);
        end
        do_txn(1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 32'h100, 32'h0, 32'h0, 32'h0,
               0, 1, 1, 1'b0, r, nb);
        do_txn(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 32'h100, 32'h0, 32'h0, 32'h0,
               0, 1, 1, 1'b0, r, nb);
    endtask

    task automatic test_noop();
        @(negedge clk);
        req_valid = 1'b1; ren = 1'b0; wen = 1'b0; addr = 32'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (stall !== 1'b0 || req_ready !== 1'b1 || bus_req !== 1'b0 || resp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL noop: stall=%b ready=%b req=%b resp=%b, want 0 1 0 0",
                         stall, req_ready, bus_req, resp_valid);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; ren = 1'b1; rwidth = 3'd4; rsign = 1'b0; addr = 32'h200;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL wait0_entry: ready=%b stall=%b, want 0 1", req_ready, stall);
        end
        #2;
        req_valid = 1'b0; ren = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || bus_req !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b0 ||
            bus_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: ready=%b req=%b resp=%b stall=%b addr=%h, want 1 0 0 0 0",
                     req_ready, bus_req, resp_valid, stall, bus_addr);
        end
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        bus_rvalid = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || bus_req !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL abandoned: resp_valid or bus_req seen after reset, want none");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int nb;
        logic        ld;
        logic [2:0]  w;
        for (int i = 0; i < 10; i++) begin
            ld = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       w = 3'd1;
                1:       w = 3'd2;
                default: w = 3'd4;
            endcase
            do_txn(ld, ld ? w : 3'd0, 1'($urandom_range(0, 1)), ~ld, ld ? 3'd0 : w,
                   $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(1, 3), 0, 1'($urandom_range(0, 1)), r, nb);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_lw();
        test_lb_sign();
        test_stores();
        test_split_lh_wrap();
        test_backpressure();
        test_error();
        test_noop();
        test_reset_midflight();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
